iob_rom_sp_arb: RTL and testbench
=================================

Name: iob_rom_sp_arb

Overview:
- Round-robin arbiter that shares one single-port ROM (iob_rom_sp: r_en, addr, 1-cycle registered r_data) between N_REQ requesters.
- Each requester has a valid/ready request channel and a one-shot response strobe; the ROM data bus is shared.
- Sits between CPU/DMA-style readers and the ROM instance; sustains one accepted read per cycle.

Parameters:
- N_REQ, 2, number of requesters (>=2; non-power-of-2 allowed).
- DATA_W, 8, ROM data width.
- ADDR_W, 4, ROM address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- arst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  N_REQ  one-cycle strobe: rsp_data holds requester i's read data.
- rsp_data  out  DATA_W  shared response data.
- rom_r_en  out  1  to ROM r_en.
- rom_addr  out  ADDR_W  to ROM addr.
- rom_r_data  in  DATA_W  from ROM r_data.

Behaviour:
- Reset (arst high, asynchronous):
  - ptr=0, rsp_valid=0, internal in-flight tag cleared.
  - req_ready=0 and rom_r_en=0 forced combinationally while arst is high.
  - rom_addr and rsp_data are don't-care during reset.
- Arbitration (combinational):
  - grant = first i with req_valid[i]=1, searching ptr, ptr+1, ... cyclically modulo N_REQ.
  - req_ready = onehot(grant) if any valid, else 0.
  - ready never asserts without valid.
- ROM drive (same cycle):
  - rom_r_en = |req_valid.
  - rom_addr = req_addr slice of grant; holds the last value when idle.
- Pointer: on an accepted request, ptr <= grant+1, wrapping from N_REQ-1 to 0. Unchanged when idle.
- Response:
  - Accept in cycle t -> rsp_valid[grant] = 1 for exactly cycle t+1, with rsp_data = rom_r_data (passthrough).
  - Tracking uses a registered in-flight flag and grant index.
  - No response backpressure; requesters must sample rsp_data in the strobe cycle.
- Throughput: back-to-back accepts every cycle; responses return in accept order, one per cycle.
- Request hold rule: a requester keeps req_valid and req_addr stable until ready. Withdrawing valid before ready is legal and simply forfeits arbitration.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- Single requester: granted every cycle regardless of ptr.
- Reset mid-operation: the in-flight response is dropped (no rsp_valid after arst deasserts); arbitration restarts from ptr=0.
- rsp_valid is at most one-hot.

Optional Feature:
- IOB_ROM_SP_ARB_RSP_REG_EN defined:
  - rsp_data and rsp_valid pass through an extra register stage; latency from accept to strobe becomes 2 cycles.
  - Throughput is still 1 per cycle.
  - The registered rsp_data resets to 0.
- Undefined: latency is 1 cycle and rsp_data is a passthrough of rom_r_data.

Decomposition:
- Header iob_rom_sp_arb.vh holds:
  - PTR_W = $clog2(N_REQ) macro helper.
  - Default parameter values.
  - The slice macro for req_addr.
- Sub-module iob_rr_arbiter (N_REQ):
  - Inputs: clk, arst, req, ack.
  - Outputs: grant one-hot, grant_idx.
  - Owns ptr; reusable for other shared memories.
- Top holds the address mux, in-flight tag and response logic.

Test Plan (ROM preloaded rom[i]=i+32, N_REQ=3):
- Single requester 1 reads addr 0..15 back-to-back -> req_ready[1] every cycle; rsp_valid[1] one cycle later with data 0x20..0x2F in order.
- All 3 valid continuously, addrs 1/2/3 -> grants rotate 0,1,2,0,...; rsp_data 0x21,0x22,0x23 repeating, each on the matching rsp_valid bit.
- ptr=2 with requesters 0 and 2 valid -> requester 2 granted first, then 0 (wrap); no grant to 1.
- arst pulse the cycle after an accept of addr 5 -> no rsp_valid after reset; next grant goes to lowest valid index (ptr=0).
- Idle (no valid) -> rom_r_en=0, req_ready=0, rsp_valid=0 for 10 cycles; ptr unchanged.
- With IOB_ROM_SP_ARB_RSP_REG_EN: accept addr 7 at t -> rsp_valid at t+2, data 0x27.

Source files
------------

// File: rtl/iob_rom_sp_arb_pkg.sv
// Shared defaults and helpers for the round-robin single-port ROM arbiter.
package iob_rom_sp_arb_pkg;

    localparam int N_REQ_DEF  = 2;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Pointer/index width; never below 1 bit so degenerate configs still elaborate.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rom_sp_arb_rr_arbiter.sv
// Generic round-robin arbiter: first valid request at or after ptr wins;
// ptr advances past the winner whenever the grant is acknowledged.
module iob_rr_arbiter
    import iob_rom_sp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = ptr_w(N_REQ)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [PTR_W-1:0] ptr;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            ptr <= '0;
        else if (ack)
            ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/iob_rom_sp_arb.sv
// Shares one single-port ROM among N_REQ readers with round-robin arbitration.
// Define IOB_ROM_SP_ARB_RSP_REG_EN to add a response register stage (latency 2).
module iob_rom_sp_arb
    import iob_rom_sp_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rom_r_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_r_data
);

    localparam int PTR_W = ptr_w(N_REQ);
`ifdef IOB_ROM_SP_ARB_RSP_REG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [N_REQ-1:0]             grant;
    logic [PTR_W-1:0]             grant_idx;
    logic                         grant_any;
    logic                         ack;
    logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [ADDR_W-1:0]            addr_q;
    logic [STAGES:1]              vld_pipe;
    logic [STAGES:1][PTR_W-1:0]   tag_pipe;

    iob_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .clk       (clk),
        .arst      (arst),
        .req       (req_valid),
        .ack       (ack),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign ack       = grant_any & ~arst;
    assign req_ready = arst ? '0 : grant;
    assign rom_r_en  = ack;
    assign addr_v    = req_addr;
    assign rom_addr  = grant_any ? addr_v[grant_idx] : addr_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)           addr_q <= '0;
        else if (grant_any) addr_q <= addr_v[grant_idx];
    end

    // In-flight flag and tag travel alongside the ROM read latency.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= ack;
            tag_pipe[1] <= grant_idx;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign rsp_valid = vld_pipe[STAGES] ? (N_REQ'(1) << tag_pipe[STAGES]) : '0;

`ifdef IOB_ROM_SP_ARB_RSP_REG_EN
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) data_q <= '0;
        else      data_q <= rom_r_data;
    end

    assign rsp_data = data_q;
`else
    assign rsp_data = rom_r_data;
`endif

endmodule

// File: tb/tb_iob_rom_sp_arb.sv
// Self-checking bench for iob_rom_sp_arb with N_REQ=3 and a ROM model rom[i]=i+32.
module tb_iob_rom_sp_arb;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef IOB_ROM_SP_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 arst;
    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] addr;
    logic [N*AW-1:0]      req_addr;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 rom_r_en;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_r_data = '0;

    assign req_addr = addr;
    always #5 clk = ~clk;

    iob_rom_sp_arb #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rom_r_en   (rom_r_en),
        .rom_addr   (rom_addr),
        .rom_r_data (rom_r_data)
    );

    logic [DW-1:0] rom [16];
    initial for (int i = 0; i < 16; i++) rom[i] = DW'(i + 32);
    always @(posedge clk) if (rom_r_en) rom_r_data <= rom[rom_addr];

    typedef struct { int due; int idx; logic [DW-1:0] data; } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [N-1:0]  v;
        logic [AW-1:0] a0, a1, a2;
        logic [N-1:0]  rdy;
    } vec_t;
    vec_t tbl[13];

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int ptr_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [N-1:0] mgrant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        return '0;
    endfunction

    // Response monitor: each cycle either the next due response or silence.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end else begin
            chk("rsp_quiet", 32'(rsp_valid), 32'd0);
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [AW-1:0] a0, a1, a2,
                        input logic [N-1:0] exp_rdy, input string nm);
        int idx;
        @(posedge clk); #1;
        req_valid = v;
        addr[0] = a0; addr[1] = a1; addr[2] = a2;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({nm, ".r_en"}, 32'(rom_r_en), 32'(|v));
        if (exp_rdy != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) idx = i;
            chk({nm, ".addr"}, 32'(rom_addr), 32'(addr[idx]));
            sbq.push_back('{cyc + LAT, idx, DW'(32) + DW'(addr[idx])});
            ptr_m = (idx + 1) % N;
        end
    endtask

    initial begin
        tbl[0]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b001};
        tbl[1]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b010};
        tbl[2]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b100};
        tbl[3]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b001};
        tbl[4]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b010};
        tbl[5]  = '{3'b111, 4'd1,  4'd2,  4'd3,  3'b100};
        tbl[6]  = '{3'b000, 4'd0,  4'd0,  4'd0,  3'b000};
        tbl[7]  = '{3'b101, 4'd4,  4'd0,  4'd9,  3'b001};
        tbl[8]  = '{3'b010, 4'd0,  4'd6,  4'd0,  3'b010};
        tbl[9]  = '{3'b101, 4'd10, 4'd0,  4'd11, 3'b100};
        tbl[10] = '{3'b101, 4'd10, 4'd0,  4'd11, 3'b001};
        tbl[11] = '{3'b100, 4'd0,  4'd0,  4'd12, 3'b100};
        tbl[12] = '{3'b010, 4'd0,  4'd13, 4'd0,  3'b010};

        // Reset holds off grants even with every requester valid.
        arst = 1'b1;
        req_valid = 3'b111;
        addr[0] = 4'd1; addr[1] = 4'd2; addr[2] = 4'd3;
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.r_en", 32'(rom_r_en), 32'd0);
`ifdef IOB_ROM_SP_ARB_RSP_REG_EN
        chk("rst.rsp_data", 32'(rsp_data), 32'd0);
`endif
        @(posedge clk); #1;
        arst = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 13; i++)
            step(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].rdy, $sformatf("vec%0d", i));

        // Lone requester 1 streams addresses 0..15 back-to-back.
        for (int i = 0; i < 16; i++)
            step(3'b010, 4'd0, AW'(i), 4'd0, mgrant(3'b010, ptr_m), "single");

        for (int i = 0; i < 10; i++)
            step(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, "idle");
        step(3'b111, 4'd1, 4'd2, 4'd3, mgrant(3'b111, ptr_m), "post_idle");

        // Reset right after an accept drops the response and restarts at ptr=0.
        step(3'b001, 4'd5, 4'd0, 4'd0, mgrant(3'b001, ptr_m), "pre_rst");
        @(posedge clk); #1;
        arst = 1'b1;
        req_valid = '0;
        sbq.delete();
        @(negedge clk);
        chk("midrst.rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < 3; i++)
            step(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, "after_rst");
        step(3'b101, 4'd8, 4'd0, 4'd9, 3'b001, "restart");

        step(3'b001, 4'd7, 4'd0, 4'd0, mgrant(3'b001, ptr_m), "addr7");

        for (int i = 0; i < 4; i++)
            step(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, "drain");
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
